// File: rtl/imem_loader.sv
// imem_loader: loads framed little-endian words from a byte stream into insn memory, holding the core until a good frame lands
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  core_hold,
    output logic                  done,
    output logic                  error
);
    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_WIDTH);

    typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, WRITE, CHECK, DONE, ERROR} state_t;

    state_t                state_q, state_d;
    logic [15:0]           count_q, count_d;
    logic [7:0]            csum_q, csum_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [ADDR_WIDTH:0]   word_idx_q, word_idx_d;
    logic [31:0]           asm_q, asm_d;
    logic                  in_ready_q, in_ready_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  core_hold_q, core_hold_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  xfer;

    assign xfer = in_valid & in_ready_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        csum_d     = csum_q;
        byte_idx_d = byte_idx_q;
        word_idx_d = word_idx_q;
        asm_d      = asm_q;
        case (state_q)
            IDLE, DONE, ERROR: if (xfer && in_data == SYNC_BYTE) begin
                state_d = CNT_LO;
                csum_d  = '0;
            end
            CNT_LO: if (xfer) begin
                count_d[7:0] = in_data;
                csum_d       = csum_q ^ in_data;
                state_d      = CNT_HI;
            end
            CNT_HI: if (xfer) begin
                count_d[15:8] = in_data;
                csum_d        = csum_q ^ in_data;
                byte_idx_d    = '0;
                word_idx_d    = '0;
                state_d       = ({1'b0, count_d} > MAX_WORDS) ? ERROR : (count_d == '0) ? CHECK : DATA;
            end
            DATA: if (xfer) begin
                asm_d[{byte_idx_q, 3'b000} +: 8] = in_data;
                csum_d     = csum_q ^ in_data;
                byte_idx_d = byte_idx_q + 2'd1;
                state_d    = (byte_idx_q == 2'd3) ? WRITE : DATA;
            end
            WRITE: begin
                word_idx_d = word_idx_q + 1'b1;
                state_d    = (16'(word_idx_d) < count_q) ? DATA : CHECK;
            end
            CHECK: if (xfer) state_d = (in_data == csum_q) ? DONE : ERROR;
            default: state_d = IDLE;
        endcase
        // outputs are registered from the next state so they line up with it
        in_ready_d  = state_d != WRITE;
        mem_we_d    = state_d == WRITE;
        mem_addr_d  = (state_d == WRITE) ? word_idx_q[ADDR_WIDTH-1:0] : mem_addr_q;
        mem_wdata_d = (state_d == WRITE) ? asm_d : mem_wdata_q;
        core_hold_d = state_d != DONE;
        done_d      = state_d == DONE;
        error_d     = state_d == ERROR;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            csum_q      <= '0;
            byte_idx_q  <= '0;
            word_idx_q  <= '0;
            asm_q       <= '0;
            in_ready_q  <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            core_hold_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            csum_q      <= csum_d;
            byte_idx_q  <= byte_idx_d;
            word_idx_q  <= word_idx_d;
            asm_q       <= asm_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            core_hold_q <= core_hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign core_hold = core_hold_q;
    assign done      = done_q;
    assign error     = error_q;
endmodule
